ghost_mode_scheduler: RTL and testbench
=======================================

# ghost_mode_scheduler

Sequences the global ghost behaviour mode from the pellet-tracking datapath's events: a fixed scatter/chase schedule counted in frames, frightened mode on power-pellet consumption, a warning flash near the end of frightened mode, and the escalating ghost-capture bonus. It sits between the pellet/point tracker (sources `ate_pellet` and `new_map`) and the ghost AI and score logic, which consume `mode`, `reverse_pulse` and the bonus outputs.

## Interface

Parameters:
- `SCATTER_FRAMES`, 420: scatter phase length in frames.
- `CHASE_FRAMES`, 1200: chase phase length in frames (phases 1, 3, 5).
- `FRIGHT_FRAMES`, 360: frightened duration in frames.
- `FLASH_FRAMES`, 120: final frightened frames with `fright_flash` high; must be < `FRIGHT_FRAMES`.
- `TIMER_W`, 11: frame-timer width; every frame parameter must be < 2^`TIMER_W`.

Ports:
- `Clk` in 1: single system clock.
- `Reset` in 1: asynchronous, active-high reset.
- `frame_clk` in 1: frame clock from VGA; sampled as data, not used as a clock.
- `ate_pellet` in 1: power-pellet level; rising edge starts/extends frightened mode.
- `ghost_eaten` in 1: single-`Clk` pulse when Pac-Man captures a frightened ghost.
- `new_map` in 1: level restart; level-sensitive, synchronous.
- `mode` out 2: 0 SCATTER, 1 CHASE, 2 FRIGHT.
- `fright_flash` out 1: high in last `FLASH_FRAMES` frames of FRIGHT.
- `reverse_pulse` out 1: one-`Clk` pulse commanding ghosts to reverse.
- `phase_idx` out 3: current schedule phase 0..7.
- `ghost_bonus` out 12: capture bonus value, valid with `bonus_valid`.
- `bonus_valid` out 1: one-`Clk` pulse.

## Operation

- Frame tick: `frame_clk` through 2-flop synchronizer; `tick` = one-cycle pulse on synchronized 0->1.
- Pellet edge: registered `ate_pellet`; `pellet_rise` = 0->1.
- Schedule: even phases 0,2,4,6 = SCATTER; odd 1,3,5 = CHASE for `CHASE_FRAMES`; phase 7 = CHASE, never ends.
- States: RUN, FRIGHT. RUN: `mode` = phase parity. Phase timer counts ticks; on tick with timer = length-1, timer -> 0, `phase_idx`++, `reverse_pulse`.
- `pellet_rise` (either state): -> FRIGHT, fright timer loaded to `FRIGHT_FRAMES`, combo -> 0, `reverse_pulse`. Phase timer frozen during FRIGHT.
- FRIGHT: timer decrements per tick; `fright_flash` = (timer <= `FLASH_FRAMES`) and FRIGHT. On tick at timer = 1: -> RUN, resume frozen phase/timer, no reverse.
- `ghost_eaten` in FRIGHT: `ghost_bonus` = 200 << combo (200/400/800/1600), `bonus_valid`; combo saturates at 3. Ignored in RUN.
- `new_map`: phase 0, timers 0, RUN, combo 0, no outputs pulsed; held high keeps block there.

## Timing

- Reset values: `mode`=0, `phase_idx`=0, `fright_flash`=0, `reverse_pulse`=0, `ghost_bonus`=0, `bonus_valid`=0; state RUN, synchronizer flops 0.
- All outputs registered; `tick` 3 `Clk` after `frame_clk` rise; outputs change the cycle after the causing tick/edge.
- Priority: `new_map` > `pellet_rise` > fright expiry > phase advance.
- `pellet_rise` same cycle as fright expiry: stay FRIGHT, reload.
- `ghost_eaten` same cycle as `pellet_rise`: bonus uses pre-reset combo, combo ends at 0.
- `Reset` mid-FRIGHT: immediate return to reset values.

## Configuration

- `GHOST_BONUS_EN` defined: combo counter and bonus outputs as above.
- Not defined: combo logic absent; `ghost_bonus` tied 0, `bonus_valid` tied 0; mode scheduling unchanged.

## Structure

- Package `pacman_pkg`: `ghost_mode_t` enum (SCATTER, CHASE, FRIGHT), `BONUS_BASE` = 200, `NUM_PHASES` = 8.
- Sub-module `frame_tick_sync`: 2-flop synchronizer + rising-edge detect producing `tick`.

## Test plan

- Reset, 420 ticks -> `mode` 0->1, `phase_idx` 0->1, one `reverse_pulse`; after further 1200 ticks -> phase 2, SCATTER.
- Run to phase 7, 5000 ticks -> `mode` stays CHASE, `phase_idx` 7.
- At phase 1 tick 100, raise `ate_pellet` -> FRIGHT, `reverse_pulse`; flash at remaining 120; after 360 ticks -> CHASE, phase timer resumes at 100.
- Five `ghost_eaten` pulses in FRIGHT -> bonuses 200, 400, 800, 1600, 1600; `ghost_eaten` in RUN -> no `bonus_valid`.
- Second `ate_pellet` rise at fright timer 10 -> timer reloaded to 360, next capture = 200.
- `new_map` during FRIGHT at phase 3 -> next cycle `mode`=0, `phase_idx`=0, `fright_flash`=0, no `reverse_pulse`.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared types and constants for the ghost mode scheduler: mode encoding, schedule size, bonus base.
// Pure definitions, no logic; no flow control.
package pacman_pkg;

    typedef enum logic [1:0] {
        SCATTER = 2'd0,
        CHASE   = 2'd1,
        FRIGHT  = 2'd2
    } ghost_mode_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FRIGHT = 1'b1
    } sched_state_t;

    localparam int BONUS_BASE = 200;
    localparam int BONUS_W    = 12;
    localparam int NUM_PHASES = 8;
    localparam int PHASE_W    = $clog2(NUM_PHASES);
    localparam int COMBO_MAX  = 3;

    // 200 << combo gives 200/400/800/1600 for combo 0..3
    function automatic logic [BONUS_W-1:0] bonus_for(input logic [1:0] combo);
        return BONUS_W'(BONUS_BASE) << combo;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the VGA frame clock into the Clk domain as data and emits a one-cycle tick per rising edge.
// Latency: tick is registered, 3 clk after frame_clk rises; no backpressure (free-running pulse).
module frame_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic frame_clk,
    output logic tick
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            tick    <= 1'b0;
        end else begin
            sync1   <= frame_clk;
            sync2   <= sync1;
            sync2_d <= sync2;
            tick    <= sync2 & ~sync2_d;
        end
    end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global ghost mode sequencer (scatter/chase schedule, frightened mode, capture bonus when GHOST_BONUS_EN).
// Outputs registered, change the cycle after the causing tick/edge; no backpressure, events never stall.
module ghost_mode_scheduler
    import pacman_pkg::*;
#(
    parameter int SCATTER_FRAMES = 420,
    parameter int CHASE_FRAMES   = 1200,
    parameter int FRIGHT_FRAMES  = 360,
    parameter int FLASH_FRAMES   = 120,
    parameter int TIMER_W        = 11
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        ate_pellet,
    input  logic        ghost_eaten,
    input  logic        new_map,
    output logic [1:0]  mode,
    output logic        fright_flash,
    output logic        reverse_pulse,
    output logic [2:0]  phase_idx,
    output logic [11:0] ghost_bonus,
    output logic        bonus_valid
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
    localparam logic [TIMER_W-1:0] T_ONE      = TIMER_W'(1);

    logic tick;
    logic pellet_q;
    logic pellet_rise;

    sched_state_t       state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [TIMER_W-1:0] ptimer_q, ptimer_d;
    logic [TIMER_W-1:0] ftimer_q, ftimer_d;
    logic [TIMER_W-1:0] phase_len;
    ghost_mode_t        mode_q, mode_d;
    logic               flash_q, flash_d;
    logic               rev_q, rev_d;

    frame_tick_sync u_tick (
        .clk       (Clk),
        .rst       (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign pellet_rise = ate_pellet & ~pellet_q;

`ifdef GHOST_BONUS_EN
    logic [1:0]         combo_q, combo_d;
    logic [BONUS_W-1:0] bonus_q, bonus_d;
    logic               bvalid_q, bvalid_d;
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        ptimer_d  = ptimer_q;
        ftimer_d  = ftimer_q;
        rev_d     = 1'b0;
        phase_len = phase_q[0] ? TIMER_W'(CHASE_FRAMES) : TIMER_W'(SCATTER_FRAMES);
`ifdef GHOST_BONUS_EN
        combo_d   = combo_q;
        bonus_d   = bonus_q;
        bvalid_d  = 1'b0;
`endif

        if (new_map) begin
            state_d  = ST_RUN;
            phase_d  = '0;
            ptimer_d = '0;
            ftimer_d = '0;
`ifdef GHOST_BONUS_EN
            combo_d  = '0;
`endif
        end else begin
`ifdef GHOST_BONUS_EN
            // Bonus is taken from the combo before any same-cycle pellet clears it
            if (ghost_eaten && state_q == ST_FRIGHT) begin
                bonus_d  = bonus_for(combo_q);
                bvalid_d = 1'b1;
                if (combo_q != 2'(COMBO_MAX))
                    combo_d = combo_q + 2'd1;
            end
`endif
            if (pellet_rise) begin
                state_d  = ST_FRIGHT;
                ftimer_d = TIMER_W'(FRIGHT_FRAMES);
                rev_d    = 1'b1;
`ifdef GHOST_BONUS_EN
                combo_d  = '0;
`endif
            end else if (state_q == ST_FRIGHT) begin
                // Phase timer is left untouched so the schedule resumes where it stopped
                if (tick) begin
                    if (ftimer_q == T_ONE) begin
                        state_d  = ST_RUN;
                        ftimer_d = '0;
                    end else begin
                        ftimer_d = ftimer_q - T_ONE;
                    end
                end
            end else if (tick && phase_q != LAST_PHASE) begin
                if (ptimer_q == phase_len - T_ONE) begin
                    ptimer_d = '0;
                    phase_d  = phase_q + PHASE_W'(1);
                    rev_d    = 1'b1;
                end else begin
                    ptimer_d = ptimer_q + T_ONE;
                end
            end
        end

        if (state_d == ST_FRIGHT)
            mode_d = FRIGHT;
        else
            mode_d = phase_d[0] ? CHASE : SCATTER;
        flash_d = (state_d == ST_FRIGHT) && (ftimer_d <= TIMER_W'(FLASH_FRAMES));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_RUN;
            phase_q  <= '0;
            ptimer_q <= '0;
            ftimer_q <= '0;
            mode_q   <= SCATTER;
            flash_q  <= 1'b0;
            rev_q    <= 1'b0;
            pellet_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            ptimer_q <= ptimer_d;
            ftimer_q <= ftimer_d;
            mode_q   <= mode_d;
            flash_q  <= flash_d;
            rev_q    <= rev_d;
            pellet_q <= ate_pellet;
        end
    end

`ifdef GHOST_BONUS_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            combo_q  <= '0;
            bonus_q  <= '0;
            bvalid_q <= 1'b0;
        end else begin
            combo_q  <= combo_d;
            bonus_q  <= bonus_d;
            bvalid_q <= bvalid_d;
        end
    end

    assign ghost_bonus = bonus_q;
    assign bonus_valid = bvalid_q;
`else
    logic unused_ghost_eaten;
    assign unused_ghost_eaten = ghost_eaten;
    assign ghost_bonus        = '0;
    assign bonus_valid        = 1'b0;
`endif

    assign mode          = mode_q;
    assign fright_flash  = flash_q;
    assign reverse_pulse = rev_q;
    assign phase_idx     = phase_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Randomised-timing bench for ghost_mode_scheduler against a frame-count reference model.
module tb_ghost_mode_scheduler;

    localparam int SCAT = 420;
    localparam int CHAS = 1200;
    localparam int FRIG = 360;
    localparam int FLSH = 120;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        ate_pellet = 1'b0;
    logic        ghost_eaten = 1'b0;
    logic        new_map = 1'b0;
    logic [1:0]  mode;
    logic        fright_flash;
    logic        reverse_pulse;
    logic [2:0]  phase_idx;
    logic [11:0] ghost_bonus;
    logic        bonus_valid;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    ghost_mode_scheduler dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .ate_pellet    (ate_pellet),
        .ghost_eaten   (ghost_eaten),
        .new_map       (new_map),
        .mode          (mode),
        .fright_flash  (fright_flash),
        .reverse_pulse (reverse_pulse),
        .phase_idx     (phase_idx),
        .ghost_bonus   (ghost_bonus),
        .bonus_valid   (bonus_valid)
    );

    // Reference model: schedule position in frames, frightened frames remaining, capture combo
    int m_phase = 0;
    int m_cnt = 0;
    int m_fright = 0;
    int m_combo = 0;
    int exp_rev = 0;
    int rev_cnt = 0;
    int exp_bonus[$];
    int got_bonus[$];

    always @(negedge Clk) begin
        if (reverse_pulse === 1'b1) rev_cnt++;
        if (bonus_valid === 1'b1) got_bonus.push_back(int'(ghost_bonus));
    end

    function automatic int phase_len(input int p);
        return (p % 2 == 1) ? CHAS : SCAT;
    endfunction

    function automatic logic [1:0] exp_mode();
        return (m_fright > 0) ? 2'd2 : 2'(m_phase % 2);
    endfunction

    function automatic logic exp_flash();
        return (m_fright > 0) && (m_fright <= FLSH);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_fright = 0; m_combo = 0;
    endtask

    task automatic model_tick();
        if (m_fright > 0) begin
            m_fright--;
        end else if (m_phase != 7) begin
            m_cnt++;
            if (m_cnt == phase_len(m_phase)) begin
                m_cnt = 0;
                m_phase++;
                exp_rev++;
            end
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            @(negedge Clk);
            frame_clk = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge Clk);
            model_tick();
        end
        repeat (5) @(negedge Clk);
    endtask

    task automatic pellet();
        ate_pellet = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge Clk);
        ate_pellet = 1'b0;
        repeat (2) @(negedge Clk);
        m_fright = FRIG;
        m_combo = 0;
        exp_rev++;
    endtask

    task automatic eat();
        if (m_fright > 0) begin
`ifdef GHOST_BONUS_EN
            exp_bonus.push_back(200 << m_combo);
            if (m_combo < 3) m_combo++;
`endif
        end
        ghost_eaten = 1'b1;
        @(negedge Clk);
        ghost_eaten = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if ({mode, phase_idx, fright_flash, reverse_pulse, ghost_bonus, bonus_valid} !== 20'd0) begin
            errors++;
            $display("FAIL reset_values got mode=%0d phase=%0d flash=%0d rev=%0d bonus=%0d bv=%0d, want all 0",
                     mode, phase_idx, fright_flash, reverse_pulse, ghost_bonus, bonus_valid);
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_schedule();
        tick_n(SCAT - 1);
        checks++;
        if (mode !== exp_mode() || phase_idx !== 3'(m_phase)) begin
            errors++;
            $display("FAIL sched_pre_p1 got mode=%0d phase=%0d want %0d %0d", mode, phase_idx, exp_mode(), m_phase);
        end
        tick_n(1);
        checks++;
        if (mode !== exp_mode() || phase_idx !== 3'(m_phase) || rev_cnt !== exp_rev) begin
            errors++;
            $display("FAIL sched_p1 got mode=%0d phase=%0d rev=%0d want %0d %0d %0d",
                     mode, phase_idx, rev_cnt, exp_mode(), m_phase, exp_rev);
        end
        tick_n(CHAS);
        checks++;
        if (mode !== exp_mode() || phase_idx !== 3'(m_phase) || rev_cnt !== exp_rev) begin
            errors++;
            $display("FAIL sched_p2 got mode=%0d phase=%0d rev=%0d want %0d %0d %0d",
                     mode, phase_idx, rev_cnt, exp_mode(), m_phase, exp_rev);
        end
    endtask

    task automatic test_new_map();
        tick_n(SCAT);
        pellet();
        tick_n($urandom_range(5, 30));
        checks++;
        if (mode !== exp_mode() || phase_idx !== 3'(m_phase) || rev_cnt !== exp_rev) begin
            errors++;
            $display("FAIL nm_setup got mode=%0d phase=%0d rev=%0d want %0d %0d %0d",
                     mode, phase_idx, rev_cnt, exp_mode(), m_phase, exp_rev);
        end
        new_map = 1'b1;
        @(negedge Clk);
        model_reset();
        checks++;
        if ({mode, phase_idx, fright_flash, reverse_pulse} !== 7'd0) begin
            errors++;
            $display("FAIL nm_next_cycle got mode=%0d phase=%0d flash=%0d rev=%0d want 0 0 0 0",
                     mode, phase_idx, fright_flash, reverse_pulse);
        end
        for (int i = 0; i < 6; i++) begin
            frame_clk = 1'b1;
            @(negedge Clk);
            frame_clk = 1'b0;
            @(negedge Clk);
        end
        repeat (5) @(negedge Clk);
        checks++;
        if (mode !== 2'd0 || phase_idx !== 3'd0 || rev_cnt !== exp_rev) begin
            errors++;
            $display("FAIL nm_held got mode=%0d phase=%0d rev=%0d want 0 0 %0d", mode, phase_idx, rev_cnt, exp_rev);
        end
        new_map = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_fright();
        tick_n(SCAT + 100);
        pellet();
        checks++;
        if (mode !== 2'd2 || fright_flash !== 1'b0 || rev_cnt !== exp_rev) begin
            errors++;
            $display("FAIL fr_enter got mode=%0d flash=%0d rev=%0d want 2 0 %0d", mode, fright_flash, rev_cnt, exp_rev);
        end
        tick_n(FRIG - FLSH - 1);
        checks++;
        if (mode !== exp_mode() || fright_flash !== exp_flash()) begin
            errors++;
            $display("FAIL fr_pre_flash got mode=%0d flash=%0d want %0d %0d", mode, fright_flash, exp_mode(), exp_flash());
        end
        tick_n(1);
        checks++;
        if (mode !== exp_mode() || fright_flash !== exp_flash()) begin
            errors++;
            $display("FAIL fr_flash_on got mode=%0d flash=%0d want %0d %0d", mode, fright_flash, exp_mode(), exp_flash());
        end
        tick_n(FLSH - 1);
        checks++;
        if (mode !== exp_mode() || fright_flash !== exp_flash()) begin
            errors++;
            $display("FAIL fr_last got mode=%0d flash=%0d want %0d %0d", mode, fright_flash, exp_mode(), exp_flash());
        end
        tick_n(1);
        checks++;
        if (mode !== exp_mode() || fright_flash !== exp_flash() || phase_idx !== 3'(m_phase) || rev_cnt !== exp_rev) begin
            errors++;
            $display("FAIL fr_exit got mode=%0d flash=%0d phase=%0d rev=%0d want %0d %0d %0d %0d",
                     mode, fright_flash, phase_idx, rev_cnt, exp_mode(), exp_flash(), m_phase, exp_rev);
        end
        tick_n(CHAS - 100 - 1);
        checks++;
        if (mode !== exp_mode() || phase_idx !== 3'(m_phase)) begin
            errors++;
            $display("FAIL fr_resume_hold got mode=%0d phase=%0d want %0d %0d", mode, phase_idx, exp_mode(), m_phase);
        end
        tick_n(1);
        checks++;
        if (mode !== exp_mode() || phase_idx !== 3'(m_phase) || rev_cnt !== exp_rev) begin
            errors++;
            $display("FAIL fr_resume_adv got mode=%0d phase=%0d rev=%0d want %0d %0d %0d",
                     mode, phase_idx, rev_cnt, exp_mode(), m_phase, exp_rev);
        end
    endtask

    task automatic test_bonus();
        got_bonus.delete();
        exp_bonus.delete();
        pellet();
        for (int i = 0; i < 5; i++) begin
            tick_n($urandom_range(0, 15));
            eat();
        end
        checks++;
        if (got_bonus.size() != exp_bonus.size()) begin
            errors++;
            $display("FAIL bonus_count got %0d want %0d", got_bonus.size(), exp_bonus.size());
        end else begin
            for (int i = 0; i < exp_bonus.size(); i++) begin
                checks++;
                if (got_bonus[i] != exp_bonus[i]) begin
                    errors++;
                    $display("FAIL bonus_value[%0d] got %0d want %0d", i, got_bonus[i], exp_bonus[i]);
                end
            end
        end
        tick_n(m_fright);
        got_bonus.delete();
        exp_bonus.delete();
        eat();
        checks++;
        if (got_bonus.size() != 0 || mode !== exp_mode()) begin
            errors++;
            $display("FAIL bonus_in_run got pulses=%0d mode=%0d want 0 %0d", got_bonus.size(), mode, exp_mode());
        end
    endtask

    task automatic test_repellet();
        got_bonus.delete();
        exp_bonus.delete();
        pellet();
        tick_n(FRIG - 10);
        checks++;
        if (mode !== exp_mode() || fright_flash !== exp_flash()) begin
            errors++;
            $display("FAIL rp_t10 got mode=%0d flash=%0d want %0d %0d", mode, fright_flash, exp_mode(), exp_flash());
        end
        eat();
        pellet();
        eat();
        checks++;
        if (got_bonus.size() != exp_bonus.size() || (exp_bonus.size() > 0 && got_bonus[$] != exp_bonus[$])) begin
            errors++;
            $display("FAIL rp_bonus got n=%0d last=%0d want n=%0d last=%0d", got_bonus.size(),
                     (got_bonus.size() > 0) ? got_bonus[$] : -1, exp_bonus.size(),
                     (exp_bonus.size() > 0) ? exp_bonus[$] : -1);
        end
        tick_n(FRIG - 1);
        checks++;
        if (mode !== exp_mode() || fright_flash !== exp_flash()) begin
            errors++;
            $display("FAIL rp_reloaded got mode=%0d flash=%0d want %0d %0d", mode, fright_flash, exp_mode(), exp_flash());
        end
        tick_n(1);
        checks++;
        if (mode !== exp_mode() || rev_cnt !== exp_rev) begin
            errors++;
            $display("FAIL rp_expire got mode=%0d rev=%0d want %0d %0d", mode, rev_cnt, exp_mode(), exp_rev);
        end
    endtask

    task automatic test_reset_mid_fright();
        pellet();
        tick_n($urandom_range(3, 20));
        Reset = 1'b1;
        #1;
        checks++;
        if ({mode, phase_idx, fright_flash, reverse_pulse, ghost_bonus, bonus_valid} !== 20'd0) begin
            errors++;
            $display("FAIL reset_mid got mode=%0d phase=%0d flash=%0d rev=%0d bonus=%0d want all 0",
                     mode, phase_idx, fright_flash, reverse_pulse, ghost_bonus);
        end
        model_reset();
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_phase7();
        tick_n(4 * SCAT + 3 * CHAS);
        checks++;
        if (mode !== exp_mode() || phase_idx !== 3'(m_phase) || rev_cnt !== exp_rev) begin
            errors++;
            $display("FAIL p7_reach got mode=%0d phase=%0d rev=%0d want %0d %0d %0d",
                     mode, phase_idx, rev_cnt, exp_mode(), m_phase, exp_rev);
        end
        tick_n(5000);
        checks++;
        if (mode !== exp_mode() || phase_idx !== 3'(m_phase) || rev_cnt !== exp_rev) begin
            errors++;
            $display("FAIL p7_hold got mode=%0d phase=%0d rev=%0d want %0d %0d %0d",
                     mode, phase_idx, rev_cnt, exp_mode(), m_phase, exp_rev);
        end
    endtask

    initial begin
        test_reset();
        test_schedule();
        test_new_map();
        test_fright();
        test_bonus();
        test_repellet();
        test_reset_mid_fright();
        test_phase7();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
